// File: rtl/cpu_retire_trace.sv
// Retirement trace recorder for a multi-cycle CPU: circular pre-trigger history,
// PC-match trigger with a fixed post-trigger window, oldest-first valid/ready readout.
module cpu_retire_trace #(
   parameter int         DEPTH    = 16,
   parameter int         ADDR_W   = 4,
   parameter logic [2:0] IF_STATE = 3'b000,
   parameter int         POST_CNT = 8
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              arm,
   input  logic [31:0]       trig_pc,
   input  logic [2:0]        state,
   input  logic [2:0]        nextState,
   input  logic [31:0]       curPC,
   input  logic [31:0]       instr,
   input  logic [4:0]        rd,
   input  logic [31:0]       DB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_instr,
   output logic [4:0]        out_rd,
   output logic [31:0]       out_db,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} fsm_t;

   fsm_t              fsm, fsm_nx;
   logic [100:0]      mem [DEPTH];
   logic [100:0]      rd_entry;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr, post_left;
   logic              retire, capture, trig_hit, beat;

   // An instruction retires on the cycle the CPU leaves a non-fetch state for fetch.
   assign retire   = (state != IF_STATE) && (nextState == IF_STATE);
   assign capture  = retire && ((fsm == S_ARMED) || (fsm == S_POST));
   assign trig_hit = (fsm == S_ARMED) && retire && (curPC == trig_pc);
   assign beat     = out_valid && out_ready;

   always_ff @(posedge CLK) begin
      if (Reset) fsm <= S_IDLE;
      else       fsm <= fsm_nx;
   end

   always_comb begin
      fsm_nx = fsm;
      if (arm) begin
         fsm_nx = S_ARMED;
      end else begin
         case (fsm)
            S_IDLE:  fsm_nx = S_IDLE;
            S_ARMED: if (trig_hit) fsm_nx = (POST_CNT == 0) ? S_DONE : S_POST;
            S_POST:  if (retire && (post_left == ADDR_W'(1))) fsm_nx = S_DONE;
            S_DONE:  if (beat && (count == (ADDR_W+1)'(1))) fsm_nx = S_IDLE;
            default: fsm_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         post_left <= '0;
      end else if (arm) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         post_left <= '0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr + 1'b1;
            // Full buffer: the oldest entry is overwritten, so the read side advances with it.
            if (count == (ADDR_W+1)'(DEPTH)) rd_ptr <= rd_ptr + 1'b1;
            else                             count  <= count + 1'b1;
         end
         if (trig_hit)                        post_left <= ADDR_W'(POST_CNT);
         else if ((fsm == S_POST) && retire)  post_left <= post_left - 1'b1;
         if (beat) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset && !arm && capture) mem[wr_ptr] <= {curPC, instr, rd, DB};
   end

   assign rd_entry  = mem[rd_ptr];
   assign out_valid = (fsm == S_DONE) && (count != '0);
   assign out_pc    = out_valid ? rd_entry[100:69] : 32'd0;
   assign out_instr = out_valid ? rd_entry[68:37]  : 32'd0;
   assign out_rd    = out_valid ? rd_entry[36:32]  : 5'd0;
   assign out_db    = out_valid ? rd_entry[31:0]   : 32'd0;
   assign busy      = (fsm == S_ARMED) || (fsm == S_POST);
   assign done      = (fsm == S_DONE);

endmodule
